// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath.
// - RsaWidth    : default operand width used across the RSA blocks.
// - rsa_state_e : state encoding of the Montgomery constant calculator FSM.
package rsa_pkg;

  localparam int unsigned RsaWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } rsa_state_e;

endpackage

// File: rtl/rsa_mod_dbl.sv
// One modular doubling step: r_nxt = (2*r) mod p, assuming r < p.
// Ports:
//   r_i     - current remainder (must be < p_i)
//   p_i     - modulus
//   r_nxt_o - next remainder, always < p_i
module rsa_mod_dbl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] r_nxt_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] p_ext;

  always_comb begin
    t     = {r_i, 1'b0};
    p_ext = {1'b0, p_i};
    // r < p gives t < 2p, so one conditional subtract is enough and the result fits WIDTH bits.
    r_nxt_o = (t >= p_ext) ? WIDTH'(t - p_ext) : WIDTH'(t);
  end

endmodule

// File: rtl/rsa_const_calc.sv
// Computes Const = 2^(2*WIDTH) mod P by 2*WIDTH modular doublings starting from 1.
// Ports:
//   clk   - clock, rising edge
//   rstb  - asynchronous active-low reset
//   ena   - enable; low freezes all state and masks done
//   start - level-sampled request, accepted only in idle
//   stop  - abort in progress computation (also blocks a start in idle)
//   P     - modulus, captured on the accepting edge
//   busy  - computation in progress
//   done  - one-cycle completion pulse
//   err   - sticky illegal-modulus flag (P < 3 or even)
//   Const - last successful result
module rsa_const_calc
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RsaWidth
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Const
);

  localparam int unsigned CntW = $clog2(2 * WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(2 * WIDTH - 1);

  rsa_state_e       state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_nxt;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] const_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             p_bad;

  assign p_bad = (P < WIDTH'(3)) || !P[0];

  rsa_mod_dbl #(
    .WIDTH(WIDTH)
  ) u_mod_dbl (
    .r_i    (r_q),
    .p_i    (p_q),
    .r_nxt_o(r_nxt)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      p_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      const_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            p_q   <= P;
            err_q <= p_bad;
            if (!p_bad) begin
              r_q     <= WIDTH'(1);
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            r_q   <= r_nxt;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastIter) begin
              const_q <= r_nxt;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= !stop;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // done_q is held while disabled, so a pending pulse appears once ena returns.
  assign done  = done_q & ena;
  assign busy  = busy_q;
  assign err   = err_q;
  assign Const = const_q;

endmodule

// File: tb/tb_rsa_const_calc.sv
module tb_rsa_const_calc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] P = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] Const;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rsa_const_calc #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .start(start),
    .stop (stop),
    .P    (P),
    .busy (busy),
    .done (done),
    .err  (err),
    .Const(Const)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold start for exactly one edge, then scramble P to show it is not re-read.
  task automatic accept(input logic [W-1:0] p);
    start = 1'b1;
    P     = p;
    tick();
    start = 1'b0;
    P     = ~p;
  endtask

  task automatic wait_done(inout int n, input int limit);
    do begin
      tick();
      n++;
    end while (!done && n < limit);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      tick();
      if (done) seen = 1;
    end
    check(tag, seen, 0);
  endtask

  task automatic run_ok(input string tag, input logic [W-1:0] p, input logic [W-1:0] exp);
    int n;
    n = 0;
    accept(p);
    check({tag, " busy"}, busy, 1);
    wait_done(n, 60);
    check({tag, " latency"}, n, 17);
    check({tag, " const"}, Const, exp);
    check({tag, " err"}, err, 0);
    tick();
    check({tag, " done width"}, done, 0);
    check({tag, " busy after"}, busy, 0);
  endtask

  initial begin
    int n;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst const", Const, 0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    run_ok("p251", 8'd251, 8'd25);
    run_ok("p3", 8'd3, 8'd1);
    run_ok("p255", 8'd255, 8'd1);
    run_ok("p131", 8'd131, 8'd36);

    // Illegal moduli: flag set, nothing starts, result kept.
    accept(8'd4);
    check("p4 err", err, 1);
    check("p4 busy", busy, 0);
    check("p4 const", Const, 36);
    watch_no_done("p4 no done", 20);
    accept(8'd1);
    check("p1 err", err, 1);
    check("p1 busy", busy, 0);
    check("p1 const", Const, 36);
    watch_no_done("p1 no done", 20);
    run_ok("p251 clr err", 8'd251, 8'd25);

    // Abort in CALC cycle 5.
    run_ok("p3b", 8'd3, 8'd1);
    accept(8'd251);
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop busy", busy, 0);
    watch_no_done("stop no done", 25);
    check("stop const", Const, 1);
    check("stop err", err, 0);

    // Start and stop together in idle: not accepted.
    start = 1'b1;
    stop  = 1'b1;
    P     = 8'd131;
    tick();
    check("start+stop busy", busy, 0);
    start = 1'b0;
    stop  = 1'b0;
    watch_no_done("start+stop no done", 25);
    check("start+stop const", Const, 1);

    // Freeze for 10 cycles mid-CALC, then a start during busy that must be ignored.
    n = 0;
    accept(8'd251);
    repeat (5) begin
      tick();
      n++;
    end
    ena = 1'b0;
    repeat (10) begin
      tick();
      n++;
    end
    check("ena busy held", busy, 1);
    check("ena done low", done, 0);
    ena   = 1'b1;
    start = 1'b1;
    P     = 8'd3;
    repeat (3) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_done(n, 80);
    check("ena latency", n, 27);
    check("ena const", Const, 25);
    tick();
    check("ena done width", done, 0);
    check("ena busy after", busy, 0);

    // Asynchronous reset between edges, mid-CALC.
    accept(8'd251);
    repeat (6) tick();
    #3;
    rstb = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst err", err, 0);
    check("arst const", Const, 0);
    @(negedge clk);
    rstb = 1'b1;
    run_ok("p131 after rst", 8'd131, 8'd36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
